// File: rtl/uart_program_loader.sv
// Purpose : framed UART program loader; parses sync/count/LE words/XOR checksum,
//           writes words to instruction memory, holds the CPU in reset meanwhile.
// Latency : every output is registered, one cycle after the byte or start causing it.
// Backpressure: none; every rx_done cycle is consumed, so bytes may arrive back to back.
// Ports   : clk/reset (sync, active-low); start; rx_data/rx_done byte strobe in;
//           mem_we/mem_addr/mem_wdata memory write out; cpu_hold, busy,
//           load_done (pulse), load_err (sticky) status out.
module uart_program_loader #(
   parameter int         ADDR_WIDTH = 8,
   parameter int         TIMEOUT    = 1024,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [7:0]            rx_data,
   input  logic                  rx_done,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic                  cpu_hold,
   output logic                  busy,
   output logic                  load_done,
   output logic                  load_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_SYNC, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERROR
   } state_t;

   // idle counter only needs to reach TIMEOUT-1; the next silent cycle fires
   localparam int              TW        = $clog2(TIMEOUT);
   localparam logic [TW-1:0]   IDLE_LAST = TW'(TIMEOUT - 1);
   // words_left must hold the full 2^ADDR_WIDTH count
   localparam int              WLW       = ADDR_WIDTH + 1;
   localparam int unsigned     MAX_WORDS = 2 ** ADDR_WIDTH;

   state_t                  state;
   logic [WLW-1:0]          words_left;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [1:0]              idx;
   logic [23:0]             word;
   logic [7:0]              csum;
   logic [TW-1:0]           idle_cnt;

   logic timed;
   logic timeout_hit;

   assign timed       = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
   // a byte arriving on the would-be timeout cycle is processed instead
   assign timeout_hit = timed && !rx_done && (idle_cnt == IDLE_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= S_IDLE;
         words_left <= '0;
         wr_addr    <= '0;
         idx        <= '0;
         word       <= '0;
         csum       <= '0;
         idle_cnt   <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_hold   <= 1'b0;
         busy       <= 1'b0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         mem_we    <= 1'b0;
         load_done <= 1'b0;

         // leaving the timed states also clears the counter, covering state entry
         if (!timed || rx_done) idle_cnt <= '0;
         else                   idle_cnt <= idle_cnt + TW'(1);

         if (timeout_hit) begin
            state    <= S_ERROR;
            load_err <= 1'b1;
            cpu_hold <= 1'b1;
            busy     <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (start) begin
                     state    <= S_SYNC;
                     cpu_hold <= 1'b1;
                     busy     <= 1'b1;
                  end
               end
               S_SYNC: begin
                  if (rx_done && rx_data == SYNC_BYTE) state <= S_COUNT;
               end
               S_COUNT: begin
                  if (rx_done) begin
                     if (rx_data == 8'd0 || 32'(rx_data) > MAX_WORDS) begin
                        state    <= S_ERROR;
                        load_err <= 1'b1;
                        cpu_hold <= 1'b1;
                        busy     <= 1'b0;
                     end else begin
                        words_left <= WLW'(rx_data);
                        wr_addr    <= '0;
                        idx        <= '0;
                        csum       <= '0;
                        state      <= S_DATA;
                     end
                  end
               end
               S_DATA: begin
                  if (rx_done) begin
                     csum <= csum ^ rx_data;
                     idx  <= idx + 2'd1;
                     case (idx)
                        2'd0: word[7:0]   <= rx_data;
                        2'd1: word[15:8]  <= rx_data;
                        2'd2: word[23:16] <= rx_data;
                        default: begin
                           // 4th byte completes the word; bypass it straight to the write port
                           mem_we     <= 1'b1;
                           mem_addr   <= wr_addr;
                           mem_wdata  <= {rx_data, word};
                           wr_addr    <= wr_addr + ADDR_WIDTH'(1);
                           words_left <= words_left - WLW'(1);
                           if (words_left == WLW'(1)) state <= S_CHECK;
                        end
                     endcase
                  end
               end
               S_CHECK: begin
                  if (rx_done) begin
                     if (rx_data == csum) begin
                        state     <= S_DONE;
                        load_done <= 1'b1;
                        cpu_hold  <= 1'b0;
                        busy      <= 1'b0;
                     end else begin
                        state    <= S_ERROR;
                        load_err <= 1'b1;
                        cpu_hold <= 1'b1;
                        busy     <= 1'b0;
                     end
                  end
               end
               S_DONE: state <= S_IDLE;
               S_ERROR: begin
                  if (start) begin
                     state    <= S_SYNC;
                     load_err <= 1'b0;
                     cpu_hold <= 1'b1;
                     busy     <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_program_loader.sv
// Purpose : self-checking bench for uart_program_loader with randomized frames,
//           checked against a positional frame model (sync/count/payload/checksum offsets).
// Latency : checks sample outputs 1 time unit after the edge that registered them.
// Backpressure: none; bytes are driven back to back or with random short gaps.
module tb_uart_program_loader;

   localparam int         AW   = 3;
   localparam int         TO   = 16;
   localparam int         NW   = 8;      // 2^AW
   localparam logic [7:0] SYNC = 8'hA5;

   typedef logic [7:0] bq_t[$];

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          start = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_done = 1'b0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_wdata;
   logic          cpu_hold;
   logic          busy;
   logic          load_done;
   logic          load_err;

   int n_checks = 0;
   int n_pass   = 0;
   int wr_cnt   = 0;

   uart_program_loader #(.ADDR_WIDTH(AW), .TIMEOUT(TO), .SYNC_BYTE(SYNC)) dut (
      .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_done(rx_done),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done), .load_err(load_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (mem_we === 1'b1) wr_cnt++;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic idle_cycle();
      rx_done = 1'b0;
      rx_data = 8'($urandom);
      @(posedge clk); #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic st);
      rx_data = b;
      rx_done = 1'b1;
      start   = st;
      @(posedge clk); #1;
      rx_done = 1'b0;
      start   = 1'b0;
      rx_data = 8'($urandom);
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      repeat (2) begin
         start   = 1'($urandom);
         rx_done = 1'($urandom);
         rx_data = 8'($urandom);
         @(posedge clk); #1;
      end
      start   = 1'b0;
      rx_done = 1'b0;
      n_checks++;
      if ({mem_we, mem_addr, mem_wdata, cpu_hold, busy, load_done, load_err} !== '0)
         $display("FAIL reset_outputs: got we=%b addr=%h wdata=%h hold=%b busy=%b done=%b err=%b, want all 0",
                  mem_we, mem_addr, mem_wdata, cpu_hold, busy, load_done, load_err);
      else n_pass++;
      reset = 1'b1;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n_checks++;
      if ({cpu_hold, busy, load_err} !== 3'b110)
         $display("FAIL start: got hold/busy/err=%b%b%b want 110", cpu_hold, busy, load_err);
      else n_pass++;
   endtask

   task automatic build_frame(input int n, input int junk, input bit bad, output bq_t q);
      logic [7:0] x;
      logic [7:0] cs;
      q  = {};
      cs = 8'h00;
      repeat (junk) begin
         do x = 8'($urandom); while (x == SYNC);
         q.push_back(x);
      end
      q.push_back(SYNC);
      q.push_back(8'(n));
      repeat (4 * n) begin
         x = 8'($urandom);
         q.push_back(x);
         cs ^= x;
      end
      if (bad) cs ^= 8'($urandom_range(255, 1));
      q.push_back(cs);
   endtask

   // Sends a frame and checks every byte's registered effect against a model
   // that locates the sync, count, payload and checksum by position.
   task automatic run_frame(input bq_t b, input int max_gap, input int start_at);
      int s, n, cidx, eidx, oidx, pos, w0, exp_wr;
      logic [7:0]    cs;
      bit            ok, exp_we, exp_done, exp_err, exp_busy, exp_hold;
      logic [AW-1:0] exp_addr;
      logic [31:0]   exp_data;
      s = -1;
      foreach (b[i]) if (s < 0 && b[i] == SYNC) s = i;
      n    = int'(b[s+1]);
      ok   = 1'b0;
      cidx = -1;
      if (n == 0 || n > NW) eidx = s + 1;
      else begin
         cidx = s + 2 + 4 * n;
         cs   = 8'h00;
         for (int k = s + 2; k < cidx; k++) cs ^= b[k];
         ok   = (b[cidx] == cs);
         eidx = ok ? -1 : cidx;
      end
      oidx   = (eidx >= 0) ? eidx : cidx;
      exp_wr = (cidx >= 0) ? n : 0;
      w0     = wr_cnt;
      for (int i = 0; i < b.size(); i++) begin
         repeat ($urandom_range(max_gap, 0)) idle_cycle();
         send_byte(b[i], (i == start_at));
         pos      = i - (s + 2);
         exp_we   = (cidx >= 0) && (pos >= 0) && (i < cidx) && (pos % 4 == 3);
         exp_done = ok && (i == cidx);
         exp_err  = (eidx >= 0) && (i >= eidx);
         exp_busy = (i < oidx);
         exp_hold = exp_busy || exp_err;
         n_checks++;
         if (mem_we !== exp_we)
            $display("FAIL mem_we byte%0d: got %b want %b", i, mem_we, exp_we);
         else n_pass++;
         if (exp_we) begin
            exp_addr = AW'(pos / 4);
            exp_data = {b[i], b[i-1], b[i-2], b[i-3]};
            n_checks++;
            if (mem_addr !== exp_addr || mem_wdata !== exp_data)
               $display("FAIL write byte%0d: got addr=%h data=%h want addr=%h data=%h",
                        i, mem_addr, mem_wdata, exp_addr, exp_data);
            else n_pass++;
         end
         n_checks++;
         if ({load_done, load_err, busy, cpu_hold} !== {exp_done, exp_err, exp_busy, exp_hold})
            $display("FAIL status byte%0d: got done/err/busy/hold=%b%b%b%b want %b%b%b%b", i,
                     load_done, load_err, busy, cpu_hold, exp_done, exp_err, exp_busy, exp_hold);
         else n_pass++;
      end
      idle_cycle();
      n_checks++;
      if ({load_done, busy, cpu_hold, load_err} !== {1'b0, 1'b0, !ok, !ok})
         $display("FAIL post_frame: got done/busy/hold/err=%b%b%b%b want 00%b%b",
                  load_done, busy, cpu_hold, load_err, !ok, !ok);
      else n_pass++;
      n_checks++;
      if (wr_cnt - w0 !== exp_wr)
         $display("FAIL write_count: got %0d want %0d", wr_cnt - w0, exp_wr);
      else n_pass++;
   endtask

   task automatic test_reset();
      apply_reset();
      idle_cycle();
      n_checks++;
      if ({cpu_hold, busy} !== 2'b00)
         $display("FAIL reset_idle: got hold/busy=%b%b want 00", cpu_hold, busy);
      else n_pass++;
      do_start();
   endtask

   task automatic test_single_word();
      bq_t q;
      q = '{8'h3C, 8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
      run_frame(q, 0, -1);
      n_checks++;
      if (mem_addr !== 3'd0 || mem_wdata !== 32'h12345678)
         $display("FAIL single_word_hold: got addr=%h data=%h want 0/12345678", mem_addr, mem_wdata);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      bq_t q;
      q = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
      do_start();
      run_frame(q, 0, 4);   // start pulse mid-payload must be ignored
      n_checks++;
      if (mem_addr !== 3'd1 || mem_wdata !== 32'h00000002)
         $display("FAIL two_words_hold: got addr=%h data=%h want 1/00000002", mem_addr, mem_wdata);
      else n_pass++;
   endtask

   task automatic test_errors();
      bq_t q;
      q = '{8'h3C, 8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
      do_start();
      run_frame(q, 0, -1);
      do_start();            // from ERROR: clears load_err
      q = '{8'hA5, 8'h00};
      run_frame(q, 1, -1);
      do_start();
      q = '{8'hA5, 8'h09};   // one past the address space
      run_frame(q, 1, -1);
      do_start();
      build_frame(NW, 1, 1'b0, q);
      run_frame(q, 1, -1);
      n_checks++;
      if (mem_addr !== 3'd7)
         $display("FAIL full_space_last_addr: got %h want 7", mem_addr);
      else n_pass++;
   endtask

   task automatic test_random();
      bq_t q;
      for (int it = 0; it < 8; it++) begin
         do_start();
         build_frame($urandom_range(NW, 1), $urandom_range(2, 0), ($urandom_range(3, 0) == 0), q);
         run_frame(q, 3, -1);
      end
   endtask

   task automatic test_timeout();
      int w0;
      // silence inside DATA
      do_start();
      send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
      send_byte(8'h78, 1'b0); send_byte(8'h56, 1'b0);
      repeat (TO - 1) idle_cycle();
      n_checks++;
      if ({load_err, busy} !== 2'b01)
         $display("FAIL timeout_early: got err/busy=%b%b want 01", load_err, busy);
      else n_pass++;
      idle_cycle();
      n_checks++;
      if ({load_err, busy, cpu_hold} !== 3'b101)
         $display("FAIL timeout_fire: got err/busy/hold=%b%b%b want 101", load_err, busy, cpu_hold);
      else n_pass++;
      // byte landing on the last allowed cycle is accepted
      do_start();
      w0 = wr_cnt;
      send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
      send_byte(8'h78, 1'b0); send_byte(8'h56, 1'b0);
      repeat (TO - 1) idle_cycle();
      send_byte(8'h34, 1'b0);
      n_checks++;
      if (load_err !== 1'b0)
         $display("FAIL timeout_edge: got err=%b want 0", load_err);
      else n_pass++;
      send_byte(8'h12, 1'b0);
      n_checks++;
      if (mem_we !== 1'b1 || mem_wdata !== 32'h12345678)
         $display("FAIL timeout_edge_write: got we=%b data=%h want 1/12345678", mem_we, mem_wdata);
      else n_pass++;
      send_byte(8'h08, 1'b0);
      n_checks++;
      if ({load_done, load_err, cpu_hold} !== 3'b100 || wr_cnt - w0 !== 1)
         $display("FAIL timeout_edge_done: got done/err/hold=%b%b%b writes=%0d want 100 writes=1",
                  load_done, load_err, cpu_hold, wr_cnt - w0);
      else n_pass++;
      idle_cycle();
      // silence while waiting for the count byte
      do_start();
      send_byte(8'hA5, 1'b0);
      repeat (TO) idle_cycle();
      n_checks++;
      if (load_err !== 1'b1)
         $display("FAIL timeout_count: got err=%b want 1", load_err);
      else n_pass++;
   endtask

   task automatic test_reset_mid_data();
      int w0;
      apply_reset();
      do_start();
      send_byte(8'hA5, 1'b0); send_byte(8'h01, 1'b0);
      send_byte(8'h78, 1'b0); send_byte(8'h56, 1'b1);
      n_checks++;
      if ({busy, cpu_hold, load_err} !== 3'b110)
         $display("FAIL start_ignored: got busy/hold/err=%b%b%b want 110", busy, cpu_hold, load_err);
      else n_pass++;
      w0 = wr_cnt;
      reset = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({mem_we, mem_addr, mem_wdata, cpu_hold, busy, load_done, load_err} !== '0)
         $display("FAIL mid_reset_outputs: got we=%b addr=%h wdata=%h hold=%b busy=%b done=%b err=%b, want all 0",
                  mem_we, mem_addr, mem_wdata, cpu_hold, busy, load_done, load_err);
      else n_pass++;
      reset = 1'b1;
      send_byte(8'h34, 1'b0); send_byte(8'h12, 1'b0);
      idle_cycle();
      n_checks++;
      if (wr_cnt !== w0 || {busy, cpu_hold} !== 2'b00)
         $display("FAIL mid_reset_after: got writes=%0d busy/hold=%b%b want writes=%0d busy/hold=00",
                  wr_cnt, busy, cpu_hold, w0);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_errors();
      test_random();
      test_timeout();
      test_reset_mid_data();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
